// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte sources, round-robin by default.
// Define UART_ARB_FIXED_PRIO_EN to make the lowest valid index always win instead.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int BUSY_WAIT_CYCLES = 1024,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 system_clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_din,
    output logic                 tx_wr_en,
    input  logic                 tx_busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 active,
    output logic                 timeout_err,
    output logic [7:0]           err_count
);
    localparam int CW = $clog2(BUSY_WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

    state_t         state;
    logic [CW-1:0]  wait_cnt;
    logic [IDW-1:0] sel;
    logic           found;

`ifdef UART_ARB_FIXED_PRIO_EN
    always_comb begin
        found = |req_valid;
        sel   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--)
            if (req_valid[j]) sel = IDW'(j);
    end
`else
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] cand;

    // search starts just after the last winner and wraps
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            cand = IDW'((int'(last_grant) + 1 + j) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end
`endif

    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            req_ready   <= '0;
            tx_wr_en    <= 1'b0;
            tx_din      <= 8'h00;
            grant_id    <= '0;
            active      <= 1'b0;
            timeout_err <= 1'b0;
            err_count   <= 8'h00;
            wait_cnt    <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
            last_grant  <= IDW'(NUM_REQ - 1);
`endif
        end else begin
            req_ready   <= '0;
            tx_wr_en    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: if (found && !tx_busy) begin
                    tx_din    <= req_data[8*sel +: 8];
                    grant_id  <= sel;
`ifndef UART_ARB_FIXED_PRIO_EN
                    last_grant <= sel;
`endif
                    req_ready <= NUM_REQ'(1) << sel;
                    tx_wr_en  <= 1'b1;
                    active    <= 1'b1;
                    state     <= LOAD;
                end
                LOAD: begin
                    wait_cnt <= '0;
                    state    <= WAIT_BUSY;
                end
                // the byte is lost on timeout; its accept has already been given
                WAIT_BUSY: if (tx_busy) begin
                    state <= WAIT_DONE;
                end else if (wait_cnt == CW'(BUSY_WAIT_CYCLES - 1)) begin
                    timeout_err <= 1'b1;
                    if (err_count != 8'hff) err_count <= err_count + 8'd1;
                    active      <= 1'b0;
                    state       <= IDLE;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                WAIT_DONE: if (!tx_busy) begin
                    active <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scoreboard bench for uart_tx_arbiter with a behavioural
// transmitter, per-requester byte queues and a round-robin (or fixed-priority) order model.
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int BWC = 16;

    logic           system_clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_din;
    logic           tx_wr_en;
    logic           tx_busy = 1'b0;
    logic [1:0]     grant_id;
    logic           active;
    logic           timeout_err;
    logic [7:0]     err_count;

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_WAIT_CYCLES(BWC)) dut (
        .system_clk(system_clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .tx_din(tx_din),
        .tx_wr_en(tx_wr_en),
        .tx_busy(tx_busy),
        .grant_id(grant_id),
        .active(active),
        .timeout_err(timeout_err),
        .err_count(err_count)
    );

    int checks = 0, failures = 0, cyc = 0;
    int strobes = 0, strobe_cyc = 0, exp_err = 0, exp_last = N - 1;
    int rise_dly = 3, hold_len = 40;
    bit dead = 1'b0, rnd = 1'b0, tx_idle = 1'b1;
    logic [11:0] exp_q[$];
    logic [7:0]  src_q[N][$];

    bit m_prev_wr = 1'b0, m_prev_busy = 1'b0, m_end_chk = 1'b0, m_pend_to = 1'b0;
    int m_to_due = 0;
    logic [7:0]  m_held = 8'h00;
    logic [11:0] m_e;

    initial forever #5 system_clk = ~system_clk;
    initial forever begin
        @(posedge system_clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic bit srcs_empty();
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // which requester the arbiter should serve next, given which ones hold a byte
    function automatic int pick(input logic [N-1:0] ne);
        logic [1:0] k;
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) begin
            k = 2'(i);
            if (ne[k]) return i;
        end
`else
        for (int j = 1; j <= N; j++) begin
            k = 2'((exp_last + j) % N);
            if (ne[k]) return int'(k);
        end
`endif
        return 0;
    endfunction

    task automatic push_batch(input int cnt, input logic [N-1:0] mask, input bit seq, input logic [7:0] base);
        logic [7:0] lq[N][$];
        logic [7:0] b;
        logic [N-1:0] ne;
        int i, p;
        for (int k = 0; k < cnt; k++) begin
            if (seq) i = k % N;
            else do i = int'($urandom_range(N - 1, 0)); while (!mask[i]);
            b = seq ? base + 8'(i) : 8'($urandom);
            lq[i].push_back(b);
            src_q[i].push_back(b);
        end
        while (1) begin
            for (int r = 0; r < N; r++) ne[r] = lq[r].size() != 0;
            if (ne == '0) break;
            p = pick(ne);
            exp_q.push_back({4'(p), lq[p].pop_front()});
            exp_last = p;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (n < budget && !(exp_q.size() == 0 && srcs_empty() && !active && !tx_busy && tx_idle)) begin
            @(negedge system_clk);
            n++;
        end
        chk("idle_reached", 32'(n < budget), 1);
        repeat (3) @(negedge system_clk);
    endtask

    task automatic do_reset();
        @(negedge system_clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_tx_wr_en", 32'(tx_wr_en), 0);
        chk("rst_tx_din", 32'(tx_din), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        chk("rst_err_count", 32'(err_count), 0);
        exp_last = N - 1;
        exp_err = 0;
        exp_q.delete();
        @(negedge system_clk);
        #2 reset = 1'b1;
    endtask

    // requesters: present queue heads, retire a byte one edge after its accept
    initial begin
        logic [N-1:0] rdy;
        forever begin
            @(negedge system_clk);
            rdy = req_ready;
            @(posedge system_clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (rdy[i] && src_q[i].size() != 0) src_q[i].delete(0);
                req_valid[i] = src_q[i].size() != 0;
                req_data[8*i +: 8] = req_valid[i] ? src_q[i][0] : 8'h00;
            end
        end
    end

    // transmitter: busy rises r edges after the strobe and lasts h edges, or never when dead
    initial begin
        int r, h;
        forever begin
            @(posedge system_clk);
            #1;
            if (tx_wr_en && !dead) begin
                r = rnd ? int'($urandom_range(8, 1)) : rise_dly;
                h = rnd ? int'($urandom_range(30, 2)) : hold_len;
                tx_idle = 1'b0;
                repeat (r) @(posedge system_clk);
                #1 tx_busy = 1'b1;
                repeat (h) @(posedge system_clk);
                #1 tx_busy = 1'b0;
                tx_idle = 1'b1;
            end
        end
    end

    // monitor: pops the scoreboard on every strobe and checks framing rules each cycle
    initial forever begin
        @(negedge system_clk);
        if (!reset) begin
            m_prev_wr = 1'b0;
            m_prev_busy = 1'b0;
            m_end_chk = 1'b0;
            m_pend_to = 1'b0;
        end else begin
            if (m_end_chk) chk("active_fall", 32'(active), 0);
            m_end_chk = m_prev_busy && !tx_busy && active;
            if (tx_wr_en) begin
                chk("single_strobe", 32'(m_prev_wr), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant actual=grant %0d din 0x%0h expected=no grant cycle=%0d", grant_id, tx_din, cyc);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("grant_id", 32'(grant_id), 32'(m_e[11:8]));
                    chk("tx_din", 32'(tx_din), 32'(m_e[7:0]));
                    chk("req_ready", 32'(req_ready), 32'(1) << m_e[11:8]);
                end
                m_held = tx_din;
                strobes++;
                strobe_cyc = cyc;
                if (dead) begin
                    m_pend_to = 1'b1;
                    m_to_due = cyc + BWC + 1;
                end
            end else begin
                chk("stray_ready", 32'(req_ready), 0);
            end
            if (active && !tx_wr_en) chk("din_hold", 32'(tx_din), 32'(m_held));
            if (timeout_err) begin
                exp_err = (exp_err < 255) ? exp_err + 1 : 255;
                chk("timeout_expected", 32'(m_pend_to), 1);
                if (m_pend_to) chk("timeout_cycle", 32'(cyc), 32'(m_to_due));
                chk("err_count", 32'(err_count), 32'(exp_err));
                m_pend_to = 1'b0;
            end else if (m_pend_to && cyc >= m_to_due) begin
                chk("timeout_missing", 32'(timeout_err), 1);
                m_pend_to = 1'b0;
            end
            m_prev_wr = tx_wr_en;
            m_prev_busy = tx_busy;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=still running expected=finished cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d, k;
        @(negedge system_clk);
        do_reset();

        // single requester, busy 3 cycles after strobe for 40 cycles
        push_batch(1, 4'b0001, 1'b1, 8'h55);
        wait_idle(200);

        // all four held: A0,A1,A2,A3,A0,...
        do_reset();
        rise_dly = 2;
        hold_len = 12;
        push_batch(8, 4'b1111, 1'b1, 8'hA0);
        wait_idle(600);

        rnd = 1'b1;
        repeat (4) begin
            push_batch(int'($urandom_range(20, 5)), 4'($urandom_range(15, 1)), 1'b0, 8'h00);
            wait_idle(3000);
        end

        // launch failures
        dead = 1'b1;
        push_batch(1, 4'($urandom_range(15, 1)), 1'b0, 8'h00);
        wait_idle(200);
        chk("err_one", 32'(err_count), 1);
        dead = 1'b0;
        push_batch(6, 4'($urandom_range(15, 1)), 1'b0, 8'h00);
        wait_idle(2000);
        dead = 1'b1;
        push_batch(299, 4'($urandom_range(15, 1)), 1'b0, 8'h00);
        wait_idle(8000);
        chk("err_saturated", 32'(err_count), 255);
        dead = 1'b0;
        push_batch(5, 4'b1111, 1'b0, 8'h00);
        wait_idle(2000);
        chk("err_stays", 32'(err_count), 255);

        // foreign frame holds off grants
        rnd = 1'b0;
        rise_dly = 2;
        hold_len = 10;
        @(posedge system_clk);
        #1 tx_busy = 1'b1;
        n = strobes;
        @(negedge system_clk);
        push_batch(1, 4'b0100, 1'b0, 8'h00);
        repeat (20) @(negedge system_clk);
        chk("busy_blocks", 32'(strobes), 32'(n));
        @(posedge system_clk);
        #1 tx_busy = 1'b0;
        d = cyc;
        k = 0;
        while (strobes == n && k < 10) begin
            @(negedge system_clk);
            k++;
        end
        chk("grant_after_busy", 32'(strobe_cyc), 32'(d + 1));
        wait_idle(200);

        // reset in the middle of a frame, then round-robin restarts from 0
        hold_len = 30;
        push_batch(1, 4'b0100, 1'b0, 8'h00);
        k = 0;
        while (!(active && tx_busy) && k < 50) begin
            @(negedge system_clk);
            k++;
        end
        chk("reached_wait_done", 32'(k < 50), 1);
        @(negedge system_clk);
        do_reset();
        wait_idle(200);
        push_batch(4, 4'b1111, 1'b1, 8'h30);
        wait_idle(600);

        // requesters 1 and 3 held together
        rnd = 1'b1;
        push_batch(10, 4'b1010, 1'b0, 8'h00);
        wait_idle(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
